// File: rtl/terminal_uart_dump.sv
// terminal_uart_dump
//   Walks the terminal text buffer row by row and sends it out a UART TX pin
//   as 8N1 ASCII. A CR+LF pair follows each row. Bytes outside 0x20..0x7E go
//   out as '.'. While busy the block owns the text read port.
//
// Ports
//   clock           system clock
//   reset           synchronous, active-high; aborts any frame in flight
//   start           begins a dump; only looked at while idle
//   text_read_en    high while the block owns the text port (same as busy)
//   text_addr       text buffer read address, row*COLS + col
//   text_read_data  buffer data, valid one cycle after text_addr
//   uart_tx         serial output, idles high
//   busy            dump in progress
//   done            one-cycle pulse when the dump completes
module terminal_uart_dump #(
    parameter int CLOCK_HZ = 25_000_000,
    parameter int BAUD     = 115200,
    parameter int COLS     = 80,
    parameter int ROWS     = 30
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        text_read_en,
    output logic [11:0] text_addr,
    input  logic [7:0]  text_read_data,
    output logic        uart_tx,
    output logic        busy,
    output logic        done
);

    localparam int DIVISOR = CLOCK_HZ / BAUD;
    localparam int BW      = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam int CW      = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_SEND_CHAR,
        S_SEND_CR,
        S_SEND_LF,
        S_DONE
    } state_t;

    state_t          state, next_state;
    logic [CW-1:0]   col;
    logic [RW-1:0]   row;
    logic [11:0]     addr;
    logic [BW-1:0]   baud_cnt;
    logic [3:0]      bit_idx;
    logic [9:0]      frame;     // bits still to go; frame[0] is on the line
    logic            tx_load;
    logic [7:0]      load_byte;
    logic            sending;
    logic            bit_end;
    logic            frame_end;
    logic            last_col;
    logic            last_row;

    assign sending   = (state == S_SEND_CHAR) || (state == S_SEND_CR) || (state == S_SEND_LF);
    assign bit_end   = (baud_cnt == BW'(DIVISOR - 1));
    assign frame_end = sending && bit_end && (bit_idx == 4'd9);
    assign last_col  = (col == CW'(COLS - 1));
    assign last_row  = (row == RW'(ROWS - 1));

    // Next-state logic. tx_load fires on the edge that enters any SEND state,
    // so back-to-back frames (char -> CR -> LF) leave no idle gap.
    always_comb begin
        next_state = state;
        tx_load    = 1'b0;
        load_byte  = 8'h00;
        case (state)
            S_IDLE: if (start) next_state = S_ADDR;
            S_ADDR: next_state = S_WAIT;
            S_WAIT: begin
                next_state = S_SEND_CHAR;
                tx_load    = 1'b1;
                load_byte  = ((text_read_data >= 8'h20) && (text_read_data <= 8'h7E))
                             ? text_read_data : 8'h2E;
            end
            S_SEND_CHAR: if (frame_end) begin
                if (last_col) begin
                    next_state = S_SEND_CR;
                    tx_load    = 1'b1;
                    load_byte  = 8'h0D;
                end else begin
                    next_state = S_ADDR;
                end
            end
            S_SEND_CR: if (frame_end) begin
                next_state = S_SEND_LF;
                tx_load    = 1'b1;
                load_byte  = 8'h0A;
            end
            S_SEND_LF: if (frame_end) next_state = last_row ? S_DONE : S_ADDR;
            S_DONE:    next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            col      <= '0;
            row      <= '0;
            addr     <= '0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            frame    <= '1;
            uart_tx  <= 1'b1;
        end else begin
            state <= next_state;

            if (state == S_IDLE && start) begin
                col  <= '0;
                row  <= '0;
                addr <= '0;
            end

            // Running address tracks row*COLS+col without a multiplier.
            if (state == S_SEND_CHAR && frame_end) begin
                addr <= addr + 12'd1;
                col  <= last_col ? '0 : col + CW'(1);
            end

            if (state == S_SEND_LF && frame_end && !last_row)
                row <= row + RW'(1);

            // Frame shifter: 1s shift in behind, so after the stop bit the
            // line falls back to idle high on its own.
            if (tx_load) begin
                frame    <= {1'b1, load_byte, 1'b0};
                uart_tx  <= 1'b0;
                baud_cnt <= '0;
                bit_idx  <= '0;
            end else if (sending) begin
                if (bit_end) begin
                    baud_cnt <= '0;
                    bit_idx  <= bit_idx + 4'd1;
                    frame    <= {1'b1, frame[9:1]};
                    uart_tx  <= frame[1];
                end else begin
                    baud_cnt <= baud_cnt + BW'(1);
                end
            end
        end
    end

    assign busy         = (state != S_IDLE) && (state != S_DONE);
    assign text_read_en = busy;
    assign done         = (state == S_DONE);
    assign text_addr    = addr;

endmodule
